alu: RTL and testbench

16-bit arithmetic/logic unit of the tiny16 CPU datapath. It takes two 16-bit register operands and a 4-bit opcode from the decoder. It returns a registered 16-bit result and a 4-bit condition-flag vector to the register file and branch logic. Integer operations only; no internal state beyond the output registers.

---
 rtl/alu.sv | 177 +++++++++++++++++
 tb/tb_alu.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu - 16-bit arithmetic/logic unit for the tiny16 datapath.
//
// Each operation finishes in one cycle, and both outputs are registered.
// Reserved opcodes leave dst and flags unchanged. CMP updates only the flags.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset; it overrides any operation
//   opcode   in   4   operation select
//   ar_flag  in   1   1 = signed MUL/DIV and arithmetic SHR
//   src1     in  16   first operand
//   src2     in  16   second operand; bits [3:0] give the shift amount
//   dst      out 16   registered result
//   flags    out  4   registered {Z, N, C, V}
//
// Build option: define ALU_DIV_EN to build the divider. Without it, opcode
// 0110 acts as a reserved opcode.

module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        ar_flag,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    output logic [15:0] dst,
    output logic [3:0]  flags
);

    localparam logic [3:0] OpAdd = 4'b0011;
    localparam logic [3:0] OpSub = 4'b0100;
    localparam logic [3:0] OpMul = 4'b0101;
    localparam logic [3:0] OpDiv = 4'b0110;
    localparam logic [3:0] OpAnd = 4'b0111;
    localparam logic [3:0] OpOr  = 4'b1000;
    localparam logic [3:0] OpXor = 4'b1001;
    localparam logic [3:0] OpNot = 4'b1010;
    localparam logic [3:0] OpShl = 4'b1011;
    localparam logic [3:0] OpShr = 4'b1100;
    localparam logic [3:0] OpCmp = 4'b1101;

    logic [15:0] dst_q, dst_d;
    logic [3:0]  flags_q, flags_d;

    // Each datapath unit is computed every cycle, and the opcode selects one.
    logic [16:0]        sum;
    logic [16:0]        diff;
    logic [31:0]        prod_u;
    logic signed [31:0] prod_s;
    logic [16:0]        shl;
    logic [16:0]        shr_in;
    logic [16:0]        shr_l;
    logic signed [16:0] shr_a;
    logic               add_ovf;
    logic               sub_ovf;

    always_comb begin
        sum     = {1'b0, src1} + {1'b0, src2};
        diff    = {1'b0, src1} - {1'b0, src2};   // bit 16 is the borrow
        prod_u  = {16'h0000, src1} * {16'h0000, src2};
        prod_s  = $signed(src1) * $signed(src2);
        // Bit 16 of the left shift holds the last bit shifted out.
        // It is 0 when the shift amount is 0.
        shl     = {1'b0, src1} << src2[3:0];
        // A guard bit is appended below the LSB. After the right shift, bit 0
        // holds the last bit shifted out.
        shr_in  = {src1, 1'b0};
        shr_l   = shr_in >> src2[3:0];
        shr_a   = $signed(shr_in) >>> src2[3:0];
        add_ovf = (src1[15] == src2[15]) && (sum[15] != src1[15]);
        sub_ovf = (src1[15] != src2[15]) && (diff[15] != src1[15]);
    end

`ifdef ALU_DIV_EN
    logic [15:0]        divisor;
    logic [15:0]        quot_u;
    logic signed [15:0] quot_s;
    logic               div_zero;
    logic               div_ovf;

    always_comb begin
        div_zero = (src2 == 16'h0000);
        div_ovf  = ar_flag && (src1 == 16'h8000) && (src2 == 16'hFFFF);
        // Substitute a safe divisor for /0. The result is overridden anyway.
        divisor  = div_zero ? 16'h0001 : src2;
        quot_u   = src1 / divisor;
        quot_s   = $signed(src1) / $signed(divisor);
    end
`endif

    logic [15:0] res;
    logic        c_flag;
    logic        v_flag;
    logic        upd;
    logic        wr_dst;

    always_comb begin
        res     = 16'h0000;
        c_flag  = 1'b0;
        v_flag  = 1'b0;
        upd     = 1'b1;
        wr_dst  = 1'b1;
        dst_d   = dst_q;
        flags_d = flags_q;

        case (opcode)
            OpAdd: begin
                res    = sum[15:0];
                c_flag = sum[16];
                v_flag = add_ovf;
            end
            OpSub, OpCmp: begin
                res    = diff[15:0];
                c_flag = diff[16];
                v_flag = sub_ovf;
                wr_dst = (opcode == OpSub);
            end
            OpMul: begin
                if (ar_flag) begin
                    res    = prod_s[15:0];
                    c_flag = (prod_s[31:16] != {16{prod_s[15]}});
                end else begin
                    res    = prod_u[15:0];
                    c_flag = (prod_u[31:16] != 16'h0000);
                end
                v_flag = c_flag;
            end
`ifdef ALU_DIV_EN
            OpDiv: begin
                if (div_zero) begin
                    res    = 16'hFFFF;
                    v_flag = 1'b1;
                end else if (div_ovf) begin
                    res    = 16'h8000;
                    v_flag = 1'b1;
                end else begin
                    res = ar_flag ? quot_s : quot_u;
                end
            end
`endif
            OpAnd: res = src1 & src2;
            OpOr:  res = src1 | src2;
            OpXor: res = src1 ^ src2;
            OpNot: res = ~src1;
            OpShl: begin
                res    = shl[15:0];
                c_flag = shl[16];
            end
            OpShr: begin
                res    = ar_flag ? shr_a[16:1] : shr_l[16:1];
                c_flag = ar_flag ? shr_a[0] : shr_l[0];
            end
            default: upd = 1'b0;
        endcase

        if (upd) begin
            if (wr_dst) begin
                dst_d = res;
            end
            flags_d = {(res == 16'h0000), res[15], c_flag, v_flag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q   <= 16'h0000;
            flags_q <= 4'b0000;
        end else begin
            dst_q   <= dst_d;
            flags_q <= flags_d;
        end
    end

    assign dst   = dst_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu - directed self-checking bench for alu.
// Expected values are hand computed. DIV checks follow ALU_DIV_EN.

module tb_alu;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic        ar_flag;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [15:0] dst;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    alu dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .ar_flag (ar_flag),
        .src1    (src1),
        .src2    (src2),
        .dst     (dst),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operation and wait for the edge. Outputs are sampled 1 time unit later.
    task automatic step(input logic r, input logic [3:0] op, input logic ar,
                        input logic [15:0] a, input logic [15:0] b);
        rst     = r;
        opcode  = op;
        ar_flag = ar;
        src1    = a;
        src2    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp_d, input logic [3:0] exp_f);
        total++;
        assert (dst === exp_d) else begin
            bad++;
            $error("FAIL %s dst: observed=%h expected=%h", tag, dst, exp_d);
        end
        total++;
        assert (flags === exp_f) else begin
            bad++;
            $error("FAIL %s flags: observed=%b expected=%b", tag, flags, exp_f);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 4'b0000; ar_flag = 1'b0; src1 = '0; src2 = '0;
        step(1'b1, 4'b0011, 1'b0, 16'd1, 16'd2);
        step(1'b1, 4'b0011, 1'b0, 16'd1, 16'd2);
        check("reset", 16'h0000, 4'b0000);

        // Basic ops, 10 and 5
        step(1'b0, 4'b0011, 1'b0, 16'd10, 16'd5); check("add10_5", 16'd15, 4'b0000);
        step(1'b0, 4'b0100, 1'b0, 16'd10, 16'd5); check("sub10_5", 16'd5,  4'b0000);
        step(1'b0, 4'b0101, 1'b0, 16'd10, 16'd5); check("mul10_5", 16'd50, 4'b0000);
        step(1'b0, 4'b0110, 1'b0, 16'd10, 16'd5);
`ifdef ALU_DIV_EN
        check("div10_5", 16'd2, 4'b0000);
`else
        check("div10_5_hold", 16'd50, 4'b0000);
`endif
        step(1'b0, 4'b0111, 1'b0, 16'd10, 16'd5); check("and10_5", 16'd0,  4'b1000);
        step(1'b0, 4'b1000, 1'b0, 16'd10, 16'd5); check("or10_5",  16'd15, 4'b0000);
        step(1'b0, 4'b1001, 1'b0, 16'd10, 16'd5); check("xor10_5", 16'd15, 4'b0000);

        // Carry and overflow
        step(1'b0, 4'b0011, 1'b0, 16'hFFFF, 16'h0001); check("add_carry", 16'h0000, 4'b1010);
        step(1'b0, 4'b0011, 1'b0, 16'h7FFF, 16'h0001); check("add_ovf",   16'h8000, 4'b0101);
        step(1'b0, 4'b0100, 1'b0, 16'h8000, 16'h0001); check("sub_ovf",   16'h7FFF, 4'b0001);
        step(1'b0, 4'b0100, 1'b0, 16'd3,    16'd5);    check("sub_borrow", 16'hFFFE, 4'b0110);
        step(1'b0, 4'b1101, 1'b0, 16'd7,    16'd7);    check("cmp_eq",    16'hFFFE, 4'b1000);
        step(1'b0, 4'b1101, 1'b0, 16'd3,    16'd5);    check("cmp_lt",    16'hFFFE, 4'b0110);

        // Divide corner cases
        step(1'b0, 4'b0110, 1'b0, 16'd10, 16'd0);
`ifdef ALU_DIV_EN
        check("div_zero", 16'hFFFF, 4'b0101);
`else
        check("div_zero_hold", 16'hFFFE, 4'b0110);
`endif
        step(1'b0, 4'b0110, 1'b1, 16'hFFF6, 16'd3);
`ifdef ALU_DIV_EN
        check("div_signed", 16'hFFFD, 4'b0100);
`else
        check("div_signed_hold", 16'hFFFE, 4'b0110);
`endif
        step(1'b0, 4'b0110, 1'b1, 16'h8000, 16'hFFFF);
`ifdef ALU_DIV_EN
        check("div_ovf", 16'h8000, 4'b0101);
`else
        check("div_ovf_hold", 16'hFFFE, 4'b0110);
`endif

        // Shifts
        step(1'b0, 4'b1100, 1'b1, 16'h8001, 16'd1); check("shr_arith", 16'hC000, 4'b0110);
        step(1'b0, 4'b1100, 1'b0, 16'h8001, 16'd1); check("shr_logic", 16'h4000, 4'b0010);
        step(1'b0, 4'b1011, 1'b0, 16'h8001, 16'd1); check("shl_1",     16'h0002, 4'b0010);
        step(1'b0, 4'b1011, 1'b0, 16'h8001, 16'd0); check("shl_0",     16'h8001, 4'b0100);
        step(1'b0, 4'b1100, 1'b0, 16'h0010, 16'hFFF5); check("shr_amt5", 16'h0000, 4'b1010);

        // Multiply high-half detection
        step(1'b0, 4'b0101, 1'b0, 16'hFFFF, 16'hFFFF); check("mul_u_hi", 16'h0001, 4'b0011);
        step(1'b0, 4'b0101, 1'b1, 16'hFFFF, 16'hFFFF); check("mul_s_ok", 16'h0001, 4'b0000);
        step(1'b0, 4'b0101, 1'b1, 16'h4000, 16'h0002); check("mul_s_hi", 16'h8000, 4'b0111);

        // NOT, then reserved opcodes hold
        step(1'b0, 4'b1010, 1'b0, 16'h0000, 16'h1234); check("not0",   16'hFFFF, 4'b0100);
        step(1'b0, 4'b1111, 1'b0, 16'h0001, 16'h0001); check("rsv_f",  16'hFFFF, 4'b0100);
        step(1'b0, 4'b0000, 1'b1, 16'h0000, 16'h0000); check("rsv_0",  16'hFFFF, 4'b0100);

        // Reset during an op wins, then the next edge computes normally
        step(1'b1, 4'b0011, 1'b0, 16'h7FFF, 16'h0001); check("rst_mid",  16'h0000, 4'b0000);
        step(1'b0, 4'b0011, 1'b0, 16'h7FFF, 16'h0001); check("post_rst", 16'h8000, 4'b0101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
